svm_inference_sequencer: RTL and testbench
==========================================

Name: svm_inference_sequencer

Overview:
Controller sitting between the feature front-end and the SVM classifier core. Accepts one feature vector, then sequences the core's two-phase protocol: valence model load/compute, then arousal model load/compute. Drives the model-bank select for the support/alpha/intercept ROM mux, collects both class bits, and presents them on a backpressured output handshake. Also measures per-inference latency in cycles.

Parameters:
NBITS, 9, bits per quantized feature
F_WIDTH, 214, features per vector
CNT_WIDTH, 20, width of latency counter and timeout compare
TIMEOUT_CYCLES, 500000, watchdog limit in cycles (used only with the optional feature)

Ports:
clk  in  1  clock
rst  in  1  synchronous, active-high reset
in_features  in  NBITS*F_WIDTH  feature vector from front-end
in_valid  in  1  front-end vector valid
in_ready  out  1  sequencer can accept a vector
svm_features  out  NBITS*F_WIDTH  buffered vector to core in_features
svm_model_sel  out  1  0 = valence bank, 1 = arousal bank (ROM mux select)
svm_fin_valid  out  1  to core fin_valid
svm_fin_ready  in  1  from core fin_ready
svm_valence  in  1  core valence result
svm_arousal  in  1  core arousal result
svm_dout_valid  in  1  core result pulse
out_valence  out  1  captured valence bit
out_arousal  out  1  captured arousal bit
out_valid  out  1  result valid
out_ready  in  1  consumer ready
out_error  out  1  result invalid (timeout); constant 0 without the optional feature
busy  out  1  inference in progress (state != IDLE)
last_latency  out  CNT_WIDTH  cycles from input accept to svm_dout_valid for the last inference

Behaviour:
- Reset: state=IDLE. in_ready=1. svm_fin_valid=0. svm_model_sel=0. out_valid=0. out_valence=0. out_arousal=0. out_error=0. last_latency=0. busy=0. Feature buffer contents are don't-care. The core shares rst; reset mid-operation abandons the inference, and no output is produced.
- States: IDLE, ISSUE_V, ISSUE_A, WAIT_RES, HOLD.
- IDLE: in_ready=1. On in_valid&&in_ready, latch in_features into the buffer, clear the latency counter to 1, and go to ISSUE_V.
- ISSUE_V: svm_fin_valid=1, svm_model_sel=0. On svm_fin_ready, go to ISSUE_A.
- ISSUE_A: svm_model_sel=1, svm_fin_valid=1. The core asserts fin_ready only after finishing valence, so this state may last many cycles. On svm_fin_ready, go to WAIT_RES.
- WAIT_RES: svm_model_sel=1, svm_fin_valid=0. On svm_dout_valid, capture svm_valence/svm_arousal into out_*, copy the counter to last_latency, and go to HOLD.
- HOLD: out_valid=1. On out_ready, clear out_valid and return to IDLE. The core has no output backpressure; the captured registers are the only buffer, so no new input is accepted until HOLD drains.
- in_ready=1 only in IDLE. No same-cycle HOLD→accept bypass; the minimum gap between inferences is 1 IDLE cycle.
- svm_model_sel is registered and stable whenever svm_fin_valid=1. The ROM mux output is therefore valid in the same cycle as the handshake.
- svm_features is held constant from accept until return to IDLE.
- Latency counter: increments every cycle in ISSUE_V, ISSUE_A and WAIT_RES. It saturates at all-ones and does not wrap.
- svm_dout_valid outside WAIT_RES is ignored. svm_fin_ready in IDLE, WAIT_RES or HOLD is ignored.

Optional Feature:
SVM_SEQ_WATCHDOG_EN.
- Defined: in ISSUE_V, ISSUE_A or WAIT_RES, when the counter reaches TIMEOUT_CYCLES, go to HOLD with out_valid=1, out_error=1, out_valence=0, out_arousal=0, last_latency=TIMEOUT_CYCLES. out_error clears on the HOLD handshake.
- A dout_valid arriving in the same cycle as the timeout wins; the result is valid with out_error=0.
- The core must be reset externally after an error.
- Not defined: no watchdog; out_error tied 0.

Test Plan:
- Nominal: vector of all 1s, core model returns valence=1, arousal=0 after 300 cycles → one fin handshake with model_sel=0, then one with model_sel=1. Output valence=1, arousal=0, out_valid=1, last_latency=300.
- Backpressure: hold out_ready=0 for 50 cycles after the result → out_valid and the bits stay stable, in_ready=0 throughout. Drive in_valid=1 during this window; the new vector is not accepted until 1 cycle after the out handshake.
- Fin stall: core holds fin_ready=0 for 1000 cycles in ISSUE_A → svm_fin_valid stays 1, model_sel stays 1, svm_features unchanged. Changes on in_features are not propagated.
- Reset mid-operation: assert rst in WAIT_RES → next cycle IDLE, in_ready=1, out_valid=0. A late svm_dout_valid pulse produces no output.
- Back-to-back: two vectors with results (1,1) then (0,1), out_ready=1 → exactly two out_valid pulses with the correct bits in order. last_latency updates per inference.
- Watchdog (macro defined, TIMEOUT_CYCLES=64): core never asserts dout_valid → out_valid with out_error=1 at counter 64. Handshake returns to IDLE and clears out_error.

Source files
------------

// File: rtl/svm_inference_sequencer.sv
// svm_inference_sequencer: buffers one feature vector and sequences the SVM core
// through a valence model pass and then an arousal model pass. Both class bits are
// captured and held behind a ready/valid output, and the latency of each inference
// is measured in cycles.
// Optional watchdog: define SVM_SEQ_WATCHDOG_EN to abort a stuck inference after
// TIMEOUT_CYCLES with out_error set. Without it, out_error is tied low.

module svm_inference_sequencer #(
    parameter int unsigned NBITS          = 9,
    parameter int unsigned F_WIDTH        = 214,
    parameter int unsigned CNT_WIDTH      = 20,
    parameter int unsigned TIMEOUT_CYCLES = 500000
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NBITS*F_WIDTH-1:0] in_features,
    input  logic                     in_valid,
    output logic                     in_ready,
    output logic [NBITS*F_WIDTH-1:0] svm_features,
    output logic                     svm_model_sel,
    output logic                     svm_fin_valid,
    input  logic                     svm_fin_ready,
    input  logic                     svm_valence,
    input  logic                     svm_arousal,
    input  logic                     svm_dout_valid,
    output logic                     out_valence,
    output logic                     out_arousal,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic                     out_error,
    output logic                     busy,
    output logic [CNT_WIDTH-1:0]     last_latency
);

    localparam int unsigned          VEC_W   = NBITS * F_WIDTH;
    localparam logic [CNT_WIDTH-1:0] TMO_VAL = CNT_WIDTH'(TIMEOUT_CYCLES);
`ifdef SVM_SEQ_WATCHDOG_EN
    localparam bit                   WD_EN   = 1'b1;
`else
    localparam bit                   WD_EN   = 1'b0;
`endif

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        ISSUE_V  = 3'd1,
        ISSUE_A  = 3'd2,
        WAIT_RES = 3'd3,
        HOLD     = 3'd4
    } state_e;

    state_e                state_q, state_d;
    logic [VEC_W-1:0]      feat_q;
    logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
    logic [CNT_WIDTH-1:0]  lat_q, lat_d;
    logic                  val_q, val_d;
    logic                  aro_q, aro_d;
    logic                  in_ready_q, in_ready_d;
    logic                  busy_q, busy_d;
    logic                  fin_valid_q, fin_valid_d;
    logic                  sel_q, sel_d;
    logic                  out_valid_q, out_valid_d;

    logic                  load_c;
    logic                  active_c;
    logic                  timeout_c;
    logic                  hold_done_c;
    logic [CNT_WIDTH-1:0]  cnt_inc_c;

    // Counter increment that sticks at all-ones instead of wrapping
    assign cnt_inc_c = (&cnt_q) ? cnt_q : cnt_q + CNT_WIDTH'(1);

    // Watchdog trip: only while the core owns the inference; a result in the same cycle wins
    assign active_c    = (state_q == ISSUE_V) || (state_q == ISSUE_A) || (state_q == WAIT_RES);
    assign timeout_c   = WD_EN && active_c && (cnt_q >= TMO_VAL)
                         && !((state_q == WAIT_RES) && svm_dout_valid);
    assign hold_done_c = (state_q == HOLD) && out_ready;

    // Next-state, datapath and registered-output decode
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        lat_d   = lat_q;
        val_d   = val_q;
        aro_d   = aro_q;
        load_c  = 1'b0;

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    load_c  = 1'b1;
                    cnt_d   = CNT_WIDTH'(1);
                    state_d = ISSUE_V;
                end
            end
            ISSUE_V: begin
                cnt_d = cnt_inc_c;
                if (svm_fin_ready) begin
                    state_d = ISSUE_A;
                end
            end
            ISSUE_A: begin
                cnt_d = cnt_inc_c;
                if (svm_fin_ready) begin
                    state_d = WAIT_RES;
                end
            end
            WAIT_RES: begin
                cnt_d = cnt_inc_c;
                if (svm_dout_valid) begin
                    val_d   = svm_valence;
                    aro_d   = svm_arousal;
                    lat_d   = cnt_q;
                    state_d = HOLD;
                end
            end
            HOLD: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Watchdog abort overrides any pending handshake
        if (timeout_c) begin
            val_d   = 1'b0;
            aro_d   = 1'b0;
            lat_d   = TMO_VAL;
            state_d = HOLD;
        end

        in_ready_d  = (state_d == IDLE);
        busy_d      = (state_d != IDLE);
        fin_valid_d = (state_d == ISSUE_V) || (state_d == ISSUE_A);
        sel_d       = (state_d == ISSUE_A) || (state_d == WAIT_RES);
        out_valid_d = (state_d == HOLD);
    end

    // State and control registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            lat_q       <= '0;
            val_q       <= 1'b0;
            aro_q       <= 1'b0;
            in_ready_q  <= 1'b1;
            busy_q      <= 1'b0;
            fin_valid_q <= 1'b0;
            sel_q       <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            lat_q       <= lat_d;
            val_q       <= val_d;
            aro_q       <= aro_d;
            in_ready_q  <= in_ready_d;
            busy_q      <= busy_d;
            fin_valid_q <= fin_valid_d;
            sel_q       <= sel_d;
            out_valid_q <= out_valid_d;
        end
    end

    // Feature buffer: loaded on accept only, contents are don't-care out of reset
    always_ff @(posedge clk) begin
        if (load_c) begin
            feat_q <= in_features;
        end
    end

`ifdef SVM_SEQ_WATCHDOG_EN
    logic err_q;

    // Error flag: set by a watchdog abort, cleared by the output handshake
    always_ff @(posedge clk) begin
        if (rst) begin
            err_q <= 1'b0;
        end else if (timeout_c) begin
            err_q <= 1'b1;
        end else if (hold_done_c) begin
            err_q <= 1'b0;
        end
    end

    assign out_error = err_q;
`else
    logic unused_hold_done;
    assign unused_hold_done = hold_done_c;
    assign out_error        = 1'b0;
`endif

    assign in_ready      = in_ready_q;
    assign busy          = busy_q;
    assign svm_features  = feat_q;
    assign svm_fin_valid = fin_valid_q;
    assign svm_model_sel = sel_q;
    assign out_valid     = out_valid_q;
    assign out_valence   = val_q;
    assign out_arousal   = aro_q;
    assign last_latency  = lat_q;

endmodule

// File: tb/tb_svm_inference_sequencer.sv
// Testbench for svm_inference_sequencer: a task-driven core/consumer model with a
// transaction scoreboard of expected (valence, arousal, latency) results.

module tb_svm_inference_sequencer;

    localparam int unsigned NBITS     = 9;
    localparam int unsigned F_WIDTH   = 214;
    localparam int unsigned CNT_WIDTH = 20;
    localparam int unsigned VEC_W     = NBITS * F_WIDTH;
    localparam int unsigned WD_T      = 64;

    typedef struct {
        bit          v;
        bit          a;
        int unsigned lat;
    } res_t;

    logic                 clk = 1'b0;
    logic                 rst;
    logic [VEC_W-1:0]     in_features;
    logic                 in_valid;
    logic                 in_ready;
    logic [VEC_W-1:0]     svm_features;
    logic                 svm_model_sel;
    logic                 svm_fin_valid;
    logic                 svm_fin_ready;
    logic                 svm_valence;
    logic                 svm_arousal;
    logic                 svm_dout_valid;
    logic                 out_valence;
    logic                 out_arousal;
    logic                 out_valid;
    logic                 out_ready;
    logic                 out_error;
    logic                 busy;
    logic [CNT_WIDTH-1:0] last_latency;

    int unsigned cyc = 0;
    int          n_checks = 0;
    int          n_fail = 0;
    int          n_hs = 0;
    int          n_fin_v = 0;
    int          n_fin_a = 0;
    res_t        exp_q[$];

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Handshake monitors on the core and consumer sides
    always @(posedge clk) begin
        if (!rst && out_valid && out_ready) n_hs <= n_hs + 1;
        if (!rst && svm_fin_valid && svm_fin_ready) begin
            if (svm_model_sel) n_fin_a <= n_fin_a + 1;
            else               n_fin_v <= n_fin_v + 1;
        end
    end

    svm_inference_sequencer #(
        .NBITS(NBITS), .F_WIDTH(F_WIDTH), .CNT_WIDTH(CNT_WIDTH), .TIMEOUT_CYCLES(500000)
    ) dut (
        .clk(clk), .rst(rst),
        .in_features(in_features), .in_valid(in_valid), .in_ready(in_ready),
        .svm_features(svm_features), .svm_model_sel(svm_model_sel),
        .svm_fin_valid(svm_fin_valid), .svm_fin_ready(svm_fin_ready),
        .svm_valence(svm_valence), .svm_arousal(svm_arousal), .svm_dout_valid(svm_dout_valid),
        .out_valence(out_valence), .out_arousal(out_arousal), .out_valid(out_valid),
        .out_ready(out_ready), .out_error(out_error), .busy(busy), .last_latency(last_latency)
    );

`ifdef SVM_SEQ_WATCHDOG_EN
    logic [VEC_W-1:0]     wd_in_features;
    logic                 wd_in_valid, wd_in_ready;
    logic [VEC_W-1:0]     wd_svm_features;
    logic                 wd_sel, wd_fin_valid, wd_fin_ready;
    logic                 wd_dv, wd_da, wd_dout_valid;
    logic                 wd_ov, wd_oa, wd_out_valid, wd_out_ready, wd_out_error, wd_busy;
    logic [CNT_WIDTH-1:0] wd_lat;

    svm_inference_sequencer #(
        .NBITS(NBITS), .F_WIDTH(F_WIDTH), .CNT_WIDTH(CNT_WIDTH), .TIMEOUT_CYCLES(WD_T)
    ) dut_wd (
        .clk(clk), .rst(rst),
        .in_features(wd_in_features), .in_valid(wd_in_valid), .in_ready(wd_in_ready),
        .svm_features(wd_svm_features), .svm_model_sel(wd_sel),
        .svm_fin_valid(wd_fin_valid), .svm_fin_ready(wd_fin_ready),
        .svm_valence(wd_dv), .svm_arousal(wd_da), .svm_dout_valid(wd_dout_valid),
        .out_valence(wd_ov), .out_arousal(wd_oa), .out_valid(wd_out_valid),
        .out_ready(wd_out_ready), .out_error(wd_out_error), .busy(wd_busy), .last_latency(wd_lat)
    );
`endif

    function automatic logic [VEC_W-1:0] rand_vec();
        logic [VEC_W-1:0] v;
        for (int i = 0; i < VEC_W; i++) v[i] = 1'($urandom_range(0, 1));
        return v;
    endfunction

    // One full inference: accept, two fin handshakes, result after 'lat' cycles, hold for 'hold' cycles.
    // Starts and ends on a falling edge; with 'chain' the next vector is offered during HOLD.
    task automatic run_inference(input logic [VEC_W-1:0] vec, input bit v, input bit a,
                                 input int unsigned dv, input int unsigned da,
                                 input int unsigned lat, input int unsigned hold,
                                 input bit noise, input bit chain,
                                 input logic [VEC_W-1:0] next_vec);
        int unsigned acc_edge;
        int unsigned guard;
        res_t        exp_r;
        res_t        got_r;
        in_features = vec;
        in_valid    = 1'b1;
        guard       = 0;
        while (in_ready !== 1'b1 && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        n_checks++;
        if (in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL accept_wait: in_ready=%b required 1", in_ready);
        end
        acc_edge = cyc + 1;
        @(negedge clk);
        in_valid = 1'b0;
        n_checks++;
        if (svm_fin_valid !== 1'b1 || svm_model_sel !== 1'b0 || busy !== 1'b1 ||
            in_ready !== 1'b0 || out_valid !== 1'b0 || svm_features !== vec) begin
            n_fail++;
            $display("FAIL issue_v_entry: fin_valid=%b sel=%b busy=%b in_ready=%b out_valid=%b feat_ok=%b required 1 0 1 0 0 1",
                     svm_fin_valid, svm_model_sel, busy, in_ready, out_valid, svm_features === vec);
        end
        for (int i = 0; i < int'(dv); i++) begin
            if (noise) begin
                in_features    = rand_vec();
                svm_dout_valid = 1'($urandom_range(0, 1));
                svm_valence    = 1'($urandom_range(0, 1));
            end
            @(negedge clk);
            n_checks++;
            if (svm_fin_valid !== 1'b1 || svm_model_sel !== 1'b0 || svm_features !== vec || out_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL issue_v_wait: fin_valid=%b sel=%b out_valid=%b feat_ok=%b required 1 0 0 1",
                         svm_fin_valid, svm_model_sel, out_valid, svm_features === vec);
            end
        end
        svm_dout_valid = 1'b0;
        svm_fin_ready  = 1'b1;
        @(negedge clk);
        svm_fin_ready = 1'b0;
        n_checks++;
        if (svm_fin_valid !== 1'b1 || svm_model_sel !== 1'b1 || svm_features !== vec || out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL issue_a_entry: fin_valid=%b sel=%b out_valid=%b feat_ok=%b required 1 1 0 1",
                     svm_fin_valid, svm_model_sel, out_valid, svm_features === vec);
        end
        for (int i = 0; i < int'(da); i++) begin
            if (noise) begin
                in_features    = rand_vec();
                svm_dout_valid = 1'($urandom_range(0, 1));
                svm_arousal    = 1'($urandom_range(0, 1));
            end
            @(negedge clk);
            n_checks++;
            if (svm_fin_valid !== 1'b1 || svm_model_sel !== 1'b1 || svm_features !== vec || out_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL issue_a_wait: fin_valid=%b sel=%b out_valid=%b feat_ok=%b required 1 1 0 1",
                         svm_fin_valid, svm_model_sel, out_valid, svm_features === vec);
            end
        end
        svm_dout_valid = 1'b0;
        svm_fin_ready  = 1'b1;
        @(negedge clk);
        svm_fin_ready = 1'b0;
        n_checks++;
        if (svm_fin_valid !== 1'b0 || svm_model_sel !== 1'b1 || busy !== 1'b1 || out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL wait_entry: fin_valid=%b sel=%b busy=%b out_valid=%b required 0 1 1 0",
                     svm_fin_valid, svm_model_sel, busy, out_valid);
        end
        while (cyc + 1 < acc_edge + lat) begin
            if (noise) svm_fin_ready = 1'($urandom_range(0, 1));
            @(negedge clk);
            n_checks++;
            if (svm_fin_valid !== 1'b0 || svm_model_sel !== 1'b1 || out_valid !== 1'b0 || svm_features !== vec) begin
                n_fail++;
                $display("FAIL wait_res: fin_valid=%b sel=%b out_valid=%b feat_ok=%b required 0 1 0 1",
                         svm_fin_valid, svm_model_sel, out_valid, svm_features === vec);
            end
        end
        svm_fin_ready  = 1'b0;
        svm_dout_valid = 1'b1;
        svm_valence    = v;
        svm_arousal    = a;
        exp_r.v   = v;
        exp_r.a   = a;
        exp_r.lat = cyc + 1 - acc_edge;
        exp_q.push_back(exp_r);
        @(negedge clk);
        svm_dout_valid = 1'b0;
        svm_valence    = ~v;
        svm_arousal    = ~a;
        got_r = exp_q.pop_front();
        for (int i = 0; i <= int'(hold); i++) begin
            if (chain) begin
                in_features = next_vec;
                in_valid    = 1'b1;
            end
            n_checks++;
            if (out_valid !== 1'b1 || out_valence !== got_r.v || out_arousal !== got_r.a ||
                last_latency !== CNT_WIDTH'(got_r.lat) || out_error !== 1'b0 ||
                in_ready !== 1'b0 || busy !== 1'b1 || svm_fin_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL hold: valid=%b bits=%b%b lat=%0d err=%b in_ready=%b busy=%b required 1 %b%b %0d 0 0 1",
                         out_valid, out_valence, out_arousal, last_latency, out_error, in_ready, busy,
                         got_r.v, got_r.a, got_r.lat);
            end
            if (i == int'(hold)) out_ready = 1'b1;
            @(negedge clk);
        end
        out_ready = 1'b0;
        n_checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0 || last_latency !== CNT_WIDTH'(got_r.lat)) begin
            n_fail++;
            $display("FAIL release: out_valid=%b in_ready=%b busy=%b lat=%0d required 0 1 0 %0d",
                     out_valid, in_ready, busy, last_latency, got_r.lat);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        n_checks++;
        if (in_ready !== 1'b1 || busy !== 1'b0 || svm_fin_valid !== 1'b0 || svm_model_sel !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_ctrl: in_ready=%b busy=%b fin_valid=%b sel=%b required 1 0 0 0",
                     in_ready, busy, svm_fin_valid, svm_model_sel);
        end
        n_checks++;
        if (out_valid !== 1'b0 || out_valence !== 1'b0 || out_arousal !== 1'b0 ||
            out_error !== 1'b0 || last_latency !== '0) begin
            n_fail++;
            $display("FAIL reset_out: valid=%b bits=%b%b err=%b lat=%0d required 0 00 0 0",
                     out_valid, out_valence, out_arousal, out_error, last_latency);
        end
        rst = 1'b0;
        @(negedge clk);
        n_checks++;
        if (in_ready !== 1'b1 || busy !== 1'b0 || out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_release: in_ready=%b busy=%b out_valid=%b required 1 0 0", in_ready, busy, out_valid);
        end
    endtask

    task automatic test_idle_ignore();
        for (int i = 0; i < 8; i++) begin
            svm_fin_ready  = 1'($urandom_range(0, 1));
            svm_dout_valid = 1'($urandom_range(0, 1));
            svm_valence    = 1'b1;
            svm_arousal    = 1'b1;
            @(negedge clk);
            n_checks++;
            if (busy !== 1'b0 || in_ready !== 1'b1 || svm_fin_valid !== 1'b0 || out_valid !== 1'b0 || svm_model_sel !== 1'b0) begin
                n_fail++;
                $display("FAIL idle_ignore: busy=%b in_ready=%b fin_valid=%b out_valid=%b sel=%b required 0 1 0 0 0",
                         busy, in_ready, svm_fin_valid, out_valid, svm_model_sel);
            end
        end
        svm_fin_ready  = 1'b0;
        svm_dout_valid = 1'b0;
    endtask

    task automatic test_nominal();
        logic [VEC_W-1:0] ones;
        int               fv0, fa0;
        ones = '1;
        fv0  = n_fin_v;
        fa0  = n_fin_a;
        run_inference(ones, 1'b1, 1'b0, 0, 0, 300, 0, 1'b0, 1'b0, '0);
        n_checks++;
        if (n_fin_v - fv0 != 1 || n_fin_a - fa0 != 1) begin
            n_fail++;
            $display("FAIL nominal_fin_count: valence=%0d arousal=%0d required 1 1", n_fin_v - fv0, n_fin_a - fa0);
        end
        n_checks++;
        if (last_latency !== CNT_WIDTH'(300) || out_valence !== 1'b1 || out_arousal !== 1'b0) begin
            n_fail++;
            $display("FAIL nominal_result: lat=%0d bits=%b%b required 300 10", last_latency, out_valence, out_arousal);
        end
    endtask

    task automatic test_backpressure();
        logic [VEC_W-1:0] va, vb;
        va = rand_vec();
        vb = rand_vec();
        run_inference(va, 1'b0, 1'b1, 2, 3, 40, 50, 1'b0, 1'b1, vb);
        n_checks++;
        if (svm_features !== va) begin
            n_fail++;
            $display("FAIL backpressure_idle_buf: buffer changed before accept, required first vector");
        end
        run_inference(vb, 1'b1, 1'b1, 0, 0, 12, 0, 1'b0, 1'b0, '0);
    endtask

    task automatic test_fin_stall();
        run_inference(rand_vec(), 1'b1, 1'b0, 1, 1000, 1010, 2, 1'b1, 1'b0, '0);
        in_features = '0;
    endtask

    task automatic test_reset_mid();
        int hs0;
        hs0         = n_hs;
        in_features = rand_vec();
        in_valid    = 1'b1;
        @(negedge clk);
        in_valid      = 1'b0;
        svm_fin_ready = 1'b1;
        repeat (2) @(negedge clk);
        svm_fin_ready = 1'b0;
        n_checks++;
        if (svm_model_sel !== 1'b1 || svm_fin_valid !== 1'b0 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_mid_setup: sel=%b fin_valid=%b busy=%b required 1 0 1", svm_model_sel, svm_fin_valid, busy);
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        n_checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0 || svm_model_sel !== 1'b0 || last_latency !== '0) begin
            n_fail++;
            $display("FAIL reset_mid: in_ready=%b out_valid=%b busy=%b sel=%b lat=%0d required 1 0 0 0 0",
                     in_ready, out_valid, busy, svm_model_sel, last_latency);
        end
        svm_dout_valid = 1'b1;
        svm_valence    = 1'b1;
        svm_arousal    = 1'b1;
        @(negedge clk);
        svm_dout_valid = 1'b0;
        out_ready      = 1'b1;
        for (int i = 0; i < 5; i++) begin
            n_checks++;
            if (out_valid !== 1'b0 || busy !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_mid_late_dout: out_valid=%b busy=%b required 0 0", out_valid, busy);
            end
            @(negedge clk);
        end
        out_ready = 1'b0;
        n_checks++;
        if (n_hs != hs0) begin
            n_fail++;
            $display("FAIL reset_mid_no_output: handshakes=%0d required 0", n_hs - hs0);
        end
    endtask

    task automatic test_back_to_back();
        int hs0;
        hs0 = n_hs;
        run_inference(rand_vec(), 1'b1, 1'b1, 0, 1, 20, 0, 1'b0, 1'b0, '0);
        run_inference(rand_vec(), 1'b0, 1'b1, 1, 0, 37, 0, 1'b0, 1'b0, '0);
        n_checks++;
        if (n_hs - hs0 != 2) begin
            n_fail++;
            $display("FAIL back_to_back_count: out handshakes=%0d required 2", n_hs - hs0);
        end
    endtask

    task automatic test_random();
        int unsigned dv, da, lat;
        for (int k = 0; k < 15; k++) begin
            dv  = $urandom_range(0, 5);
            da  = $urandom_range(0, 40);
            lat = dv + da + 3 + $urandom_range(0, 30);
            run_inference(rand_vec(), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                          dv, da, lat, $urandom_range(0, 4), 1'b1, 1'b0, '0);
        end
    endtask

`ifdef SVM_SEQ_WATCHDOG_EN
    task automatic test_watchdog();
        int unsigned acc_edge, seen;
        bit          found;
        for (int k = 0; k < 2; k++) begin
            wd_in_features = rand_vec();
            wd_in_valid    = 1'b1;
            acc_edge       = cyc + 1;
            wd_fin_ready   = 1'b1;
            @(negedge clk);
            wd_in_valid = 1'b0;
            repeat (2) @(negedge clk);
            wd_fin_ready = 1'b0;
            found = 1'b0;
            seen  = 0;
            for (int i = 0; i < 200 && !found; i++) begin
                if (k == 1 && cyc + 1 == acc_edge + WD_T) begin
                    wd_dout_valid = 1'b1;
                    wd_dv         = 1'b1;
                    wd_da         = 1'b1;
                end else begin
                    wd_dout_valid = 1'b0;
                end
                @(negedge clk);
                if (wd_out_valid === 1'b1) begin
                    found = 1'b1;
                    seen  = cyc - acc_edge;
                end
            end
            wd_dout_valid = 1'b0;
            n_checks++;
            if (!found || seen != WD_T) begin
                n_fail++;
                $display("FAIL wd_timing: found=%b at=%0d required 1 %0d", found, seen, WD_T);
            end
            n_checks++;
            if (wd_out_error !== (k == 0) || wd_ov !== (k == 1) || wd_oa !== (k == 1) || wd_lat !== CNT_WIDTH'(WD_T)) begin
                n_fail++;
                $display("FAIL wd_result: err=%b bits=%b%b lat=%0d required %b %b%b %0d",
                         wd_out_error, wd_ov, wd_oa, wd_lat, k == 0, k == 1, k == 1, WD_T);
            end
            wd_out_ready = 1'b1;
            @(negedge clk);
            wd_out_ready = 1'b0;
            n_checks++;
            if (wd_out_valid !== 1'b0 || wd_out_error !== 1'b0 || wd_in_ready !== 1'b1) begin
                n_fail++;
                $display("FAIL wd_release: valid=%b err=%b in_ready=%b required 0 0 1", wd_out_valid, wd_out_error, wd_in_ready);
            end
        end
    endtask
`endif

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation time limit reached");
        $fatal(1, "global timeout");
    end

    initial begin
        rst            = 1'b1;
        in_features    = '0;
        in_valid       = 1'b0;
        svm_fin_ready  = 1'b0;
        svm_valence    = 1'b0;
        svm_arousal    = 1'b0;
        svm_dout_valid = 1'b0;
        out_ready      = 1'b0;
`ifdef SVM_SEQ_WATCHDOG_EN
        wd_in_features = '0;
        wd_in_valid    = 1'b0;
        wd_fin_ready   = 1'b0;
        wd_dv          = 1'b0;
        wd_da          = 1'b0;
        wd_dout_valid  = 1'b0;
        wd_out_ready   = 1'b0;
`endif
        test_reset();
        test_idle_ignore();
        test_nominal();
        test_backpressure();
        test_fin_stall();
        test_reset_mid();
        test_back_to_back();
        test_random();
`ifdef SVM_SEQ_WATCHDOG_EN
        test_watchdog();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
